// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for timer_ctrl: register word addresses, CTRL/STATUS bit
// positions and the sequencing FSM state encoding.
package timer_ctrl_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_PERIOD = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_COUNT  = 3'd3;
    localparam logic [2:0] ADDR_PRESC  = 3'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;

    localparam int STAT_PEND     = 0;
    localparam int STAT_RUNNING  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

endpackage

// File: rtl/timer_ctrl_prescaler.sv
// timer_prescaler: divides the clock into a tick every (i_div+1) cycles.
// Only compiled when TIMER_CTRL_PRESCALER_EN is defined.
`ifdef TIMER_CTRL_PRESCALER_EN
module timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic [PRESC_W-1:0] i_div,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;

    assign o_tick = (r_cnt == i_div);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/timer_ctrl.sv
// timer_ctrl: bus-mapped register file and IDLE/LOAD/RUN/STOP sequencer for one
// period counter. Optional prescaler enabled by defining TIMER_CTRL_PRESCALER_EN.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_addr,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_irq,
    output logic             o_tmr_en,
    output logic             o_tmr_we,
    output logic             o_tmr_srst,
    output logic [WIDTH-1:0] o_tmr_data,
    input  logic             i_tmr_trig,
    input  logic [WIDTH-1:0] i_tmr_cnt
);

    state_t             r_state;
    state_t             w_next;
    logic               r_en;
    logic               r_periodic;
    logic               r_ie;
    logic               r_pend;
    logic               r_irq;
    logic [WIDTH-1:0]   r_period;
    logic [PRESC_W-1:0] w_presc;
    logic               w_tick;
    logic               w_wr_ctrl;
    logic               w_wr_period;
    logic               w_wr_status;
    logic               w_trig_run;
    logic               w_hw_clr;

    assign w_wr_ctrl   = i_we && (i_addr == ADDR_CTRL);
    assign w_wr_period = i_we && (i_addr == ADDR_PERIOD);
    assign w_wr_status = i_we && (i_addr == ADDR_STATUS);
    // Expiry only counts while the counter is actually owned by RUN.
    assign w_trig_run  = i_tmr_trig && (r_state == ST_RUN);
    assign w_hw_clr    = w_trig_run && !r_periodic;

`ifdef TIMER_CTRL_PRESCALER_EN
    logic               r_presc;
    logic [PRESC_W-1:0] r_presc_div;
    logic               w_wr_presc;

    assign w_wr_presc = i_we && (i_addr == ADDR_PRESC);
    assign r_presc    = (r_state == ST_LOAD);
    assign w_presc    = r_presc_div;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc_div <= '0;
        end else if (w_wr_presc) begin
            r_presc_div <= i_wdata[PRESC_W-1:0];
        end
    end

    timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (r_presc),
        .i_div   (r_presc_div),
        .o_tick  (w_tick)
    );
`else
    assign w_tick  = 1'b1;
    assign w_presc = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_ie       <= 1'b0;
            r_period   <= '0;
            r_pend     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en       <= i_wdata[CTRL_EN];
                r_periodic <= i_wdata[CTRL_PERIODIC];
                r_ie       <= i_wdata[CTRL_IE];
            end else if (w_hw_clr) begin
                r_en <= 1'b0;
            end
            if (w_wr_period) begin
                r_period <= i_wdata;
            end
            // A set from the counter beats a simultaneous software clear.
            if (w_trig_run) begin
                r_pend <= 1'b1;
            end else if (w_wr_status && i_wdata[STAT_PEND]) begin
                r_pend <= 1'b0;
            end
            r_irq <= r_pend && r_ie;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_tmr_we   = 1'b0;
        o_tmr_en   = 1'b0;
        o_tmr_srst = i_rst;
        case (r_state)
            ST_IDLE: begin
                if (r_en) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                o_tmr_we = !i_rst;
                w_next   = ST_RUN;
            end
            ST_RUN: begin
                o_tmr_en = w_tick && !i_rst;
                if (w_wr_ctrl && !i_wdata[CTRL_EN]) begin
                    w_next = ST_STOP;
                end else if (w_hw_clr) begin
                    w_next = ST_IDLE;
                end else if (w_wr_period) begin
                    w_next = ST_LOAD;
                end
            end
            ST_STOP: begin
                o_tmr_srst = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign o_tmr_data = r_period;
    assign o_irq      = r_irq;

    always_comb begin
        o_rdata = '0;
        case (i_addr)
            ADDR_CTRL: begin
                o_rdata[CTRL_EN]       = r_en;
                o_rdata[CTRL_PERIODIC] = r_periodic;
                o_rdata[CTRL_IE]       = r_ie;
            end
            ADDR_PERIOD: o_rdata = r_period;
            ADDR_STATUS: begin
                o_rdata[STAT_PEND]    = r_pend;
                o_rdata[STAT_RUNNING] = (r_state == ST_RUN);
            end
            ADDR_COUNT:  o_rdata = i_tmr_cnt;
            ADDR_PRESC:  o_rdata = WIDTH'(w_presc);
            default:     o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: a behavioural period counter closes the loop, directed
// steps with randomized periods/data are checked against expected timer behaviour.
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        irq;
    logic        tmr_en;
    logic        tmr_we;
    logic        tmr_srst;
    logic [15:0] tmr_data;

    logic [15:0] m_cnt  = '0;
    logic [15:0] m_per  = '0;
    logic        m_trig = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc    = 0;
    int n_we   = 0;
    int n_srst = 0;
    int n_trig = 0;
    int t_last = 0;
    int t_prev = 0;
    logic [15:0] last_we = '0;

    timer_ctrl #(.WIDTH(16), .PRESC_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_addr     (addr),
        .i_we       (we),
        .i_wdata    (wdata),
        .o_rdata    (rdata),
        .o_irq      (irq),
        .o_tmr_en   (tmr_en),
        .o_tmr_we   (tmr_we),
        .o_tmr_srst (tmr_srst),
        .o_tmr_data (tmr_data),
        .i_tmr_trig (m_trig),
        .i_tmr_cnt  (m_cnt)
    );

    always #5 clk = ~clk;

    // Counter: loads period and clears on the load strobe; expiry pulses one clock
    // after the enabled count reaches the period, so one expiry per (PERIOD+1) enables.
    always @(posedge clk) begin
        if (tmr_srst) begin
            m_cnt  <= '0;
            m_per  <= '0;
            m_trig <= 1'b0;
        end else begin
            m_trig <= 1'b0;
            if (tmr_we) begin
                m_cnt <= '0;
                m_per <= tmr_data;
            end else if (tmr_en) begin
                if (m_cnt == m_per) begin
                    m_cnt  <= '0;
                    m_trig <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 16'd1;
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tmr_we) begin
            n_we    <= n_we + 1;
            last_we <= tmr_data;
        end
        if (tmr_srst && !rst) n_srst <= n_srst + 1;
        if (m_trig && !rst) begin
            n_trig <= n_trig + 1;
            t_prev <= t_last;
            t_last <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wait_trigs(input int k, input string tag);
        int start;
        int c;
        start = n_trig;
        c = 0;
        while (n_trig < start + k && c < 400) begin
            tick();
            c++;
        end
        check(tag, 32'(n_trig >= start + k), 32'd1);
    endtask

    task automatic wait_trig_now(input string tag);
        int c;
        c = 0;
        while (!m_trig && c < 200) begin
            tick();
            c++;
        end
        check(tag, 32'(m_trig), 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        int p;
        int w0;
        int t0;
        int s0;
        int c;
        int presc_v;
        presc_v = 0;

        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        tick(); tick(); tick();
        check("rst_srst", 32'(tmr_srst), 32'd1);
        check("rst_we", 32'(tmr_we), 32'd0);
        rst = 1'b0;
        tick();
        rd(3'd0, d); check("rst_ctrl", 32'(d), 32'd0);
        rd(3'd1, d); check("rst_period", 32'(d), 32'd0);
        rd(3'd2, d); check("rst_status", 32'(d), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_en", 32'(tmr_en), 32'd0);

        // PERIOD write while idle just stores the value
        p = $urandom_range(1, 16'hFFFF);
        w0 = n_we;
        bus_wr(3'd1, 16'(p));
        rd(3'd1, d); check("idle_period_rb", 32'(d), 32'(p));
        tick(); tick();
        check("idle_period_noload", 32'(n_we - w0), 32'd0);

        // One-shot
        bus_wr(3'd1, 16'd4);
        w0 = n_we; t0 = n_trig;
        bus_wr(3'd0, 16'h5);
        c = 0;
        while (!irq && c < 40) begin tick(); c++; end
        check("os_irq", 32'(irq), 32'd1);
        repeat (6) tick();
        check("os_we_pulses", 32'(n_we - w0), 32'd1);
        check("os_we_data", 32'(last_we), 32'd4);
        check("os_trigs", 32'(n_trig - t0), 32'd1);
        rd(3'd0, d); check("os_ctrl", 32'(d), 32'h4);
        rd(3'd2, d); check("os_status", 32'(d), 32'h1);
        check("os_en_off", 32'(tmr_en), 32'd0);
        bus_wr(3'd2, 16'h1);
        rd(3'd2, d); check("os_w1c", 32'(d), 32'h0);
        tick();
        check("os_irq_clr", 32'(irq), 32'd0);

        // Periodic with random periods
        for (int it = 0; it < 3; it++) begin
            p = $urandom_range(0, 6);
            bus_wr(3'd1, 16'(p));
            if (it == 0) bus_wr(3'd0, 16'h7);
            wait_trigs(4, "per_wait");
            check("per_interval", 32'(t_last - t_prev), 32'((p + 1) * (presc_v + 1)));
`ifndef TIMER_CTRL_PRESCALER_EN
            check("per_en_cont", 32'(tmr_en), 32'd1);
`endif
            rd(3'd2, d); check("per_status", 32'(d), 32'h3);
            check("per_irq", 32'(irq), 32'd1);
        end

        // W1C away from an expiry drops irq one cycle later
        bus_wr(3'd1, 16'd5);
        wait_trig_now("w1c_wait");
        tick();
        bus_wr(3'd2, 16'h1);
        rd(3'd2, d); check("w1c_status", 32'(d), 32'h2);
        check("w1c_irq_hold", 32'(irq), 32'd1);
        tick();
        check("w1c_irq_fall", 32'(irq), 32'd0);

        // W1C colliding with an expiry: set wins
        wait_trig_now("col_wait1");
        tick(); tick();
        check("col_irq_pre", 32'(irq), 32'd1);
        wait_trig_now("col_wait2");
        bus_wr(3'd2, 16'h1);
        rd(3'd2, d); check("col_status", 32'(d), 32'h3);
        check("col_irq", 32'(irq), 32'd1);
        tick();
        check("col_irq_after", 32'(irq), 32'd1);

        // Reload mid-run
        w0 = n_we;
        bus_wr(3'd1, 16'd9);
        tick();
        check("rl_we_pulses", 32'(n_we - w0), 32'd1);
        check("rl_we_data", 32'(last_we), 32'd9);
        rd(3'd3, d); check("rl_count0", 32'(d), 32'd0);
        wait_trigs(3, "rl_wait");
        check("rl_interval", 32'(t_last - t_prev), 32'(10 * (presc_v + 1)));

        // Stop
        s0 = n_srst;
        bus_wr(3'd0, 16'h0);
        check("stop_srst", 32'(tmr_srst), 32'd1);
        tick();
        check("stop_srst_off", 32'(tmr_srst), 32'd0);
        check("stop_srst_cnt", 32'(n_srst - s0), 32'd1);
        check("stop_en", 32'(tmr_en), 32'd0);
        rd(3'd2, d); check("stop_running", 32'(d[1]), 32'd0);

        // Reset while running
        bus_wr(3'd1, 16'd3);
        bus_wr(3'd0, 16'h7);
        repeat (4) tick();
        rd(3'd2, d); check("rr_running", 32'(d[1]), 32'd1);
        rst = 1'b1;
        tick();
        check("rr_srst", 32'(tmr_srst), 32'd1);
        rd(3'd0, d); check("rr_ctrl", 32'(d), 32'd0);
        rd(3'd1, d); check("rr_period", 32'(d), 32'd0);
        rd(3'd2, d); check("rr_status", 32'(d), 32'd0);
        check("rr_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        t0 = n_trig; w0 = n_we;
        repeat (10) tick();
        check("rr_no_trig", 32'(n_trig - t0), 32'd0);
        check("rr_no_load", 32'(n_we - w0), 32'd0);
        check("rr_en", 32'(tmr_en), 32'd0);

`ifdef TIMER_CTRL_PRESCALER_EN
        bus_wr(3'd4, 16'hFFFF);
        rd(3'd4, d); check("ps_rb", 32'(d), 32'h00FF);
        bus_wr(3'd4, 16'd3);
        presc_v = 3;
        bus_wr(3'd1, 16'd1);
        bus_wr(3'd0, 16'h3);
        wait_trigs(3, "ps_wait");
        check("ps_interval", 32'(t_last - t_prev), 32'((1 + 1) * (presc_v + 1)));
`else
        bus_wr(3'd4, 16'hFFFF);
        rd(3'd4, d); check("presc_absent", 32'(d), 32'd0);
`endif
        for (int a = 5; a < 8; a++) begin
            bus_wr(3'(a), 16'($urandom_range(1, 16'hFFFF)));
            rd(3'(a), d); check("unmapped", 32'(d), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
